ex_mem_pipe_reg: RTL and testbench

//  Parametrised EX/MEM pipeline register for the 5-stage MIPS datapath, between ALU/branch-adder and data memory.
//  Two-entry elastic buffer (main + skid) with valid/ready handshake on both sides, synchronous flush,
//  and registered branch-select (pcsrc) generation. Replaces the fixed-width, always-enabled EX latch.

---
 rtl/ex_mem_pipe_reg.sv | 145 ++++++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg
//  EX/MEM pipeline register for the 5-stage MIPS datapath. This is a two-entry
//  elastic buffer: a head entry that drives the MEM stage, plus a skid entry.
//  Both sides use a valid/ready handshake. The buffer supports a synchronous
//  flush and derives the branch select (pcsrc) from the head entry.
//
// Ports
//  clk, rst      rising-edge clock; asynchronous active-high reset
//  flush         synchronous discard of every held entry
//  in_valid      EX stage presents a payload
//  in_ready      buffer can accept a payload (fewer than 2 entries held)
//  in_*          EX payload: wb/m control, branch target, zero flag,
//                ALU result, store data, destination register
//  out_valid     head entry is valid toward MEM
//  out_ready     MEM stage accepts the head entry
//  wb_ctl .. dest  head-entry payload; all zero while out_valid=0
//  pcsrc         out_valid & m_ctl[BRANCH_BIT] & zero
//  occupancy     number of entries held (0..2)

module ex_mem_pipe_reg #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int WB_W       = 2,
   parameter int M_W        = 3,
   parameter int BRANCH_BIT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WB_W-1:0]       in_wb_ctl,
   input  logic [M_W-1:0]        in_m_ctl,
   input  logic [DATA_W-1:0]     in_add,
   input  logic                  in_zero,
   input  logic [DATA_W-1:0]     in_alu,
   input  logic [DATA_W-1:0]     in_rdata2,
   input  logic [REG_ADDR_W-1:0] in_dest,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WB_W-1:0]       wb_ctl,
   output logic [M_W-1:0]        m_ctl,
   output logic [DATA_W-1:0]     add_result,
   output logic                  zero,
   output logic [DATA_W-1:0]     alu_result,
   output logic [DATA_W-1:0]     rdata2,
   output logic [REG_ADDR_W-1:0] dest,
   output logic                  pcsrc,
   output logic [1:0]            occupancy
);

   localparam int PW = WB_W + M_W + 3 * DATA_W + 1 + REG_ADDR_W;

   // The state encoding equals the entry count, so occupancy is the state itself.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [PW-1:0]  head;
   logic [PW-1:0]  head_next;
   logic [PW-1:0]  skid;
   logic [PW-1:0]  skid_next;
   logic [PW-1:0]  in_payload;
   logic           push;
   logic           pop;

   assign in_payload = {in_wb_ctl, in_m_ctl, in_add, in_zero, in_alu, in_rdata2, in_dest};

   // in_ready and out_valid come from the state register only. This keeps
   // out_ready from reaching in_ready through any combinational path.
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign occupancy = state;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign {wb_ctl, m_ctl, add_result, zero, alu_result, rdata2, dest} = head;

   // The head register is cleared whenever the buffer empties, so a plain AND
   // is enough to produce pcsrc = 0 while out_valid = 0.
   assign pcsrc = out_valid & m_ctl[BRANCH_BIT] & zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
         head  <= '0;
         skid  <= '0;
      end else begin
         state <= state_next;
         head  <= head_next;
         skid  <= skid_next;
      end
   end

   // Next-state and entry movement. Flush takes priority over everything.
   // A pop in the same cycle as a flush still completes the handoff to MEM,
   // because MEM samples the head before this edge.
   always_comb begin
      state_next = state;
      head_next  = head;
      skid_next  = skid;
      if (flush) begin
         state_next = EMPTY;
         head_next  = '0;
         skid_next  = '0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  state_next = ONE;
                  head_next  = in_payload;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  state_next = FULL;
                  skid_next  = in_payload;
               end else if (pop && !push) begin
                  state_next = EMPTY;
                  head_next  = '0;
               end else if (push && pop) begin
                  head_next  = in_payload;
               end
            end
            FULL: begin
               if (pop) begin
                  state_next = ONE;
                  head_next  = skid;
                  skid_next  = '0;
               end
            end
            default: begin
               state_next = EMPTY;
               head_next  = '0;
               skid_next  = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg
//  Directed testbench for ex_mem_pipe_reg using the default parameters.
//  Each scenario task drives stimulus and checks the expected values inline.

module tb_ex_mem_pipe_reg;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_wb_ctl;
   logic [2:0]  in_m_ctl;
   logic [31:0] in_add;
   logic        in_zero;
   logic [31:0] in_alu;
   logic [31:0] in_rdata2;
   logic [4:0]  in_dest;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  wb_ctl;
   logic [2:0]  m_ctl;
   logic [31:0] add_result;
   logic        zero;
   logic [31:0] alu_result;
   logic [31:0] rdata2;
   logic [4:0]  dest;
   logic        pcsrc;
   logic [1:0]  occupancy;

   int checks;
   int failures;

   ex_mem_pipe_reg dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_wb_ctl  (in_wb_ctl),
      .in_m_ctl   (in_m_ctl),
      .in_add     (in_add),
      .in_zero    (in_zero),
      .in_alu     (in_alu),
      .in_rdata2  (in_rdata2),
      .in_dest    (in_dest),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .wb_ctl     (wb_ctl),
      .m_ctl      (m_ctl),
      .add_result (add_result),
      .zero       (zero),
      .alu_result (alu_result),
      .rdata2     (rdata2),
      .dest       (dest),
      .pcsrc      (pcsrc),
      .occupancy  (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive the EX payload fields.
   task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] add,
                        input logic z, input logic [31:0] alu, input logic [31:0] rd2,
                        input logic [4:0] dst);
      in_wb_ctl = wb; in_m_ctl = m; in_add = add; in_zero = z;
      in_alu = alu; in_rdata2 = rd2; in_dest = dst;
   endtask

   // Advance one clock edge, then settle 1 ns before any sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      drive(2'd0, 3'd0, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0);
      #12;
      checks++; if (occupancy !== 2'd0) begin failures++; $display("[TB] FAIL reset_occ got=%0d exp=0", occupancy); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if ({wb_ctl, m_ctl, add_result, zero, alu_result, rdata2, dest, pcsrc} !== '0) begin
         failures++; $display("[TB] FAIL reset_payload got alu=%h add=%h exp=0", alu_result, add_result); end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_single();
      out_ready = 1'b1; in_valid = 1'b1;
      drive(2'd1, 3'd2, 32'd3, 1'b0, 32'd5, 32'd6, 5'd7);
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%b exp=1", out_valid); end
      checks++; if ({wb_ctl, m_ctl, add_result, zero, alu_result, rdata2, dest} !==
                    {2'd1, 3'd2, 32'd3, 1'b0, 32'd5, 32'd6, 5'd7}) begin
         failures++; $display("[TB] FAIL single_payload got wb=%0d m=%0d add=%0d z=%b alu=%0d rd2=%0d dest=%0d exp 1 2 3 0 5 6 7",
                              wb_ctl, m_ctl, add_result, zero, alu_result, rdata2, dest); end
      checks++; if (pcsrc !== 1'b0) begin failures++; $display("[TB] FAIL single_pcsrc got=%b exp=0", pcsrc); end
      checks++; if (occupancy !== 2'd1) begin failures++; $display("[TB] FAIL single_occ got=%0d exp=1", occupancy); end
      tick();
      checks++; if (out_valid !== 1'b0 || alu_result !== 32'd0) begin
         failures++; $display("[TB] FAIL single_drain got valid=%b alu=%h exp 0/0", out_valid, alu_result); end
   endtask

   task automatic test_stall_skid();
      out_ready = 1'b0; in_valid = 1'b1;
      drive(2'd2, 3'd1, 32'hA0, 1'b1, 32'hAAAA, 32'hA2, 5'd10);
      tick();
      drive(2'd3, 3'd0, 32'hB0, 1'b0, 32'hBBBB, 32'hB2, 5'd11);
      tick();
      in_valid = 1'b0;
      checks++; if (occupancy !== 2'd2) begin failures++; $display("[TB] FAIL stall_occ got=%0d exp=2", occupancy); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_in_ready got=%b exp=0", in_ready); end
      checks++; if (alu_result !== 32'hAAAA || dest !== 5'd10) begin
         failures++; $display("[TB] FAIL stall_head got alu=%h dest=%0d exp AAAA/10", alu_result, dest); end
      tick();
      checks++; if (out_valid !== 1'b1 || alu_result !== 32'hAAAA || add_result !== 32'hA0) begin
         failures++; $display("[TB] FAIL stall_hold got valid=%b alu=%h add=%h exp 1/AAAA/A0", out_valid, alu_result, add_result); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1 || alu_result !== 32'hBBBB || wb_ctl !== 2'd3 || rdata2 !== 32'hB2) begin
         failures++; $display("[TB] FAIL stall_second got valid=%b alu=%h wb=%0d rd2=%h exp 1/BBBB/3/B2",
                              out_valid, alu_result, wb_ctl, rdata2); end
      checks++; if (occupancy !== 2'd1) begin failures++; $display("[TB] FAIL stall_occ_one got=%0d exp=1", occupancy); end
      tick();
      checks++; if (out_valid !== 1'b0 || {wb_ctl, m_ctl, add_result, zero, alu_result, rdata2, dest} !== '0) begin
         failures++; $display("[TB] FAIL stall_empty got valid=%b alu=%h exp 0/0", out_valid, alu_result); end
   endtask

   task automatic test_branch();
      out_ready = 1'b1; in_valid = 1'b1;
      drive(2'd0, 3'b100, 32'h40, 1'b1, 32'd0, 32'd0, 5'd0);
      tick();
      checks++; if (pcsrc !== 1'b1 || add_result !== 32'h40) begin
         failures++; $display("[TB] FAIL branch_taken got pcsrc=%b add=%h exp 1/40", pcsrc, add_result); end
      drive(2'd0, 3'b100, 32'h40, 1'b0, 32'd0, 32'd0, 5'd0);
      tick();
      in_valid = 1'b0;
      checks++; if (pcsrc !== 1'b0 || out_valid !== 1'b1) begin
         failures++; $display("[TB] FAIL branch_not_taken got pcsrc=%b valid=%b exp 0/1", pcsrc, out_valid); end
      tick();
      checks++; if (pcsrc !== 1'b0 || out_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL branch_drain got pcsrc=%b valid=%b exp 0/0", pcsrc, out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1;
      drive(2'd1, 3'd1, 32'h11, 1'b0, 32'h1111, 32'h12, 5'd1);
      tick();
      drive(2'd2, 3'd2, 32'h22, 1'b0, 32'h2222, 32'h23, 5'd2);
      tick();
      checks++; if (occupancy !== 2'd2) begin failures++; $display("[TB] FAIL flush_pre_occ got=%0d exp=2", occupancy); end
      flush = 1'b1;
      drive(2'd3, 3'd3, 32'h33, 1'b1, 32'h3333, 32'h34, 5'd3);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL flush_full got occ=%0d valid=%b ready=%b exp 0/0/1", occupancy, out_valid, in_ready); end
      checks++; if (alu_result !== 32'd0) begin failures++; $display("[TB] FAIL flush_payload got alu=%h exp=0", alu_result); end
      in_valid = 1'b1;
      drive(2'd1, 3'd0, 32'h55, 1'b0, 32'h5555, 32'h56, 5'd5);
      tick();
      flush = 1'b1;
      drive(2'd2, 3'd0, 32'h66, 1'b0, 32'h6666, 32'h67, 5'd6);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || alu_result !== 32'd0) begin
         failures++; $display("[TB] FAIL flush_push_lost got occ=%0d valid=%b alu=%h exp 0/0/0", occupancy, out_valid, alu_result); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         drive(2'd0, 3'd0, 32'd0, 1'b0, 32'(i), 32'd0, 5'(i));
         tick();
         checks++; if (out_valid !== 1'b1 || alu_result !== 32'(i) || occupancy !== 2'd1) begin
            failures++; $display("[TB] FAIL stream_%0d got valid=%b alu=%0d occ=%0d exp 1/%0d/1", i, out_valid, alu_result, occupancy, i); end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      drive(2'd1, 3'b100, 32'h77, 1'b1, 32'h7777, 32'h78, 5'd7);
      tick();
      drive(2'd2, 3'd0, 32'h88, 1'b0, 32'h8888, 32'h89, 5'd8);
      tick();
      in_valid = 1'b0;
      checks++; if (occupancy !== 2'd2 || pcsrc !== 1'b1) begin
         failures++; $display("[TB] FAIL areset_pre got occ=%0d pcsrc=%b exp 2/1", occupancy, pcsrc); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || pcsrc !== 1'b0) begin
         failures++; $display("[TB] FAIL areset_ctrl got occ=%0d valid=%b ready=%b pcsrc=%b exp 0/0/1/0",
                              occupancy, out_valid, in_ready, pcsrc); end
      checks++; if ({wb_ctl, m_ctl, add_result, zero, alu_result, rdata2, dest} !== '0) begin
         failures++; $display("[TB] FAIL areset_payload got alu=%h exp=0", alu_result); end
      tick();
      rst = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         failures++; $display("[TB] FAIL areset_after got valid=%b occ=%0d exp 0/0", out_valid, occupancy); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_single();
      test_stall_skid();
      test_branch();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
